// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ALU/branch/JALR ops until both
// operands are ready. It snoops the CDB for operand values and issues at most
// one ready op per cycle onto the registered ALU input port.
// Optional macro ALU_RS_AGE_ORDER_EN: issue picks the oldest eligible entry by
// saturating age. Without it, issue picks the lowest-index eligible entry.
module alu_reservation_station #(
    parameter int RS_SIZE       = 8,
    parameter int RS_TYPE_WIDTH = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     flush,
    input  logic                     dispatch_en,
    input  logic [RS_TYPE_WIDTH-1:0] dispatch_type,
    input  logic [31:0]              dispatch_rob_id,
    input  logic                     dispatch_qj_busy,
    input  logic [31:0]              dispatch_qj,
    input  logic [31:0]              dispatch_vj,
    input  logic                     dispatch_qk_busy,
    input  logic [31:0]              dispatch_qk,
    input  logic [31:0]              dispatch_vk,
    input  logic [31:0]              dispatch_imm,
    input  logic                     cdb_en,
    input  logic [31:0]              cdb_rob_id,
    input  logic [31:0]              cdb_value,
    output logic                     full,
    output logic                     alu_en,
    output logic [31:0]              alu_rob_id,
    output logic [31:0]              alu_data_j,
    output logic [31:0]              alu_data_k,
    output logic [31:0]              alu_imm,
    output logic [RS_TYPE_WIDTH-1:0] alu_type
);
    localparam int IDX_W = $clog2(RS_SIZE);

    // Entry state: busy plus "operand still pending" flags, and payload.
    logic [RS_SIZE-1:0]       busy_q, busy_d, pj_q, pj_d, pk_q, pk_d;
    logic [RS_TYPE_WIDTH-1:0] type_q [RS_SIZE];
    logic [RS_TYPE_WIDTH-1:0] type_d [RS_SIZE];
    logic [31:0]              rob_q [RS_SIZE], rob_d [RS_SIZE];
    logic [31:0]              qj_q [RS_SIZE], qj_d [RS_SIZE];
    logic [31:0]              vj_q [RS_SIZE], vj_d [RS_SIZE];
    logic [31:0]              qk_q [RS_SIZE], qk_d [RS_SIZE];
    logic [31:0]              vk_q [RS_SIZE], vk_d [RS_SIZE];
    logic [31:0]              imm_q [RS_SIZE], imm_d [RS_SIZE];
`ifdef ALU_RS_AGE_ORDER_EN
    localparam int AGE_W = IDX_W + 1;
    logic [AGE_W-1:0]         age_q [RS_SIZE], age_d [RS_SIZE];
    logic [AGE_W-1:0]         best_age;
`endif

    // Registered issue port.
    logic                     alu_en_q, alu_en_d;
    logic [31:0]              alu_rob_q, alu_rob_d, alu_j_q, alu_j_d;
    logic [31:0]              alu_k_q, alu_k_d, alu_imm_q, alu_imm_d;
    logic [RS_TYPE_WIDTH-1:0] alu_type_q, alu_type_d;

    logic [RS_SIZE-1:0]       elig;
    logic [IDX_W-1:0]         free_idx, sel_idx;
    logic                     sel_found, disp_acc, byp_j, byp_k, k_wait;

    assign full       = &busy_q;
    assign elig       = busy_q & ~pj_q & ~pk_q;
    assign disp_acc   = dispatch_en && !full;
    assign byp_j      = cdb_en && (dispatch_qj == cdb_rob_id);
    assign byp_k      = cdb_en && (dispatch_qk == cdb_rob_id);
    // Immediate/JALR ops never wait on operand k.
    assign k_wait     = dispatch_qk_busy && !dispatch_type[4];

    assign alu_en     = alu_en_q;
    assign alu_rob_id = alu_rob_q;
    assign alu_data_j = alu_j_q;
    assign alu_data_k = alu_k_q;
    assign alu_imm    = alu_imm_q;
    assign alu_type   = alu_type_q;

    // Lowest-index free entry (scanned high to low so the lowest wins).
    always_comb begin
        free_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Issue selection over entries that were ready at the start of the cycle.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
`ifdef ALU_RS_AGE_ORDER_EN
        best_age  = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (elig[i] && (!sel_found || age_q[i] > best_age)) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
                best_age  = age_q[i];
            end
        end
`else
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
`endif
    end

    // Next state: flush, then wakeup, issue and dispatch in the same cycle.
    always_comb begin
        busy_d = busy_q;  pj_d = pj_q;  pk_d = pk_q;
        type_d = type_q;  rob_d = rob_q;  imm_d = imm_q;
        qj_d = qj_q;  vj_d = vj_q;  qk_d = qk_q;  vk_d = vk_q;
`ifdef ALU_RS_AGE_ORDER_EN
        age_d = age_q;
`endif
        alu_en_d  = alu_en_q;   alu_rob_d  = alu_rob_q;
        alu_j_d   = alu_j_q;    alu_k_d    = alu_k_q;
        alu_imm_d = alu_imm_q;  alu_type_d = alu_type_q;
        if (rdy_in) begin
            if (flush) begin
                busy_d   = '0;
                alu_en_d = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && pj_q[i] && cdb_en && qj_q[i] == cdb_rob_id) begin
                        pj_d[i] = 1'b0;
                        vj_d[i] = cdb_value;
                    end
                    if (busy_q[i] && pk_q[i] && cdb_en && qk_q[i] == cdb_rob_id) begin
                        pk_d[i] = 1'b0;
                        vk_d[i] = cdb_value;
                    end
                end
                alu_en_d = sel_found;
                if (sel_found) begin
                    busy_d[sel_idx] = 1'b0;
                    alu_rob_d       = rob_q[sel_idx];
                    alu_j_d         = vj_q[sel_idx];
                    alu_k_d         = vk_q[sel_idx];
                    alu_imm_d       = imm_q[sel_idx];
                    alu_type_d      = type_q[sel_idx];
                end
                if (disp_acc) begin
`ifdef ALU_RS_AGE_ORDER_EN
                    for (int i = 0; i < RS_SIZE; i++) begin
                        if (busy_q[i] && age_q[i] != AGE_W'(RS_SIZE))
                            age_d[i] = age_q[i] + AGE_W'(1);
                    end
                    age_d[free_idx] = '0;
`endif
                    busy_d[free_idx] = 1'b1;
                    type_d[free_idx] = dispatch_type;
                    rob_d[free_idx]  = dispatch_rob_id;
                    imm_d[free_idx]  = dispatch_imm;
                    qj_d[free_idx]   = dispatch_qj;
                    qk_d[free_idx]   = dispatch_qk;
                    pj_d[free_idx]   = dispatch_qj_busy && !byp_j;
                    pk_d[free_idx]   = k_wait && !byp_k;
                    vj_d[free_idx]   = (dispatch_qj_busy && byp_j) ? cdb_value : dispatch_vj;
                    vk_d[free_idx]   = (k_wait && byp_k) ? cdb_value : dispatch_vk;
                end
            end
        end
    end

    // Control and issue-port registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            busy_q     <= '0;
            alu_en_q   <= 1'b0;
            alu_rob_q  <= '0;
            alu_j_q    <= '0;
            alu_k_q    <= '0;
            alu_imm_q  <= '0;
            alu_type_q <= '0;
        end else begin
            busy_q     <= busy_d;
            alu_en_q   <= alu_en_d;
            alu_rob_q  <= alu_rob_d;
            alu_j_q    <= alu_j_d;
            alu_k_q    <= alu_k_d;
            alu_imm_q  <= alu_imm_d;
            alu_type_q <= alu_type_d;
        end
    end

    // Entry payload; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        pj_q <= pj_d;
        pk_q <= pk_d;
        for (int i = 0; i < RS_SIZE; i++) begin
            type_q[i] <= type_d[i];
            rob_q[i]  <= rob_d[i];
            imm_q[i]  <= imm_d[i];
            qj_q[i]   <= qj_d[i];
            vj_q[i]   <= vj_d[i];
            qk_q[i]   <= qk_d[i];
            vk_q[i]   <= vk_d[i];
`ifdef ALU_RS_AGE_ORDER_EN
            age_q[i]  <= age_d[i];
`endif
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Testbench for alu_reservation_station: directed scenarios followed by
// randomized traffic, all checked against a behavioural reservation-station model.
module tb_alu_reservation_station;
    localparam int RS_SIZE = 8;
    localparam int TW      = 6;

    logic          clk = 1'b0;
    logic          rst_n, rdy, flush;
    logic          d_en, d_qjb, d_qkb;
    logic [TW-1:0] d_type;
    logic [31:0]   d_rob, d_qj, d_vj, d_qk, d_vk, d_imm;
    logic          c_en;
    logic [31:0]   c_rob, c_val;
    logic          full, alu_en;
    logic [31:0]   alu_rob_id, alu_data_j, alu_data_k, alu_imm;
    logic [TW-1:0] alu_type;

    alu_reservation_station #(.RS_SIZE(RS_SIZE), .RS_TYPE_WIDTH(TW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush(flush),
        .dispatch_en(d_en), .dispatch_type(d_type), .dispatch_rob_id(d_rob),
        .dispatch_qj_busy(d_qjb), .dispatch_qj(d_qj), .dispatch_vj(d_vj),
        .dispatch_qk_busy(d_qkb), .dispatch_qk(d_qk), .dispatch_vk(d_vk),
        .dispatch_imm(d_imm), .cdb_en(c_en), .cdb_rob_id(c_rob), .cdb_value(c_val),
        .full(full), .alu_en(alu_en), .alu_rob_id(alu_rob_id),
        .alu_data_j(alu_data_j), .alu_data_k(alu_data_k), .alu_imm(alu_imm),
        .alu_type(alu_type)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        bit          pj, pk;
        logic [TW-1:0] typ;
        logic [31:0] rob, qj, vj, qk, vk, imm;
        int          seq;
    } ent_t;

    ent_t          m [RS_SIZE];
    int            m_ndisp;
    bit            m_en;
    logic [31:0]   m_rob, m_j, m_k, m_imm;
    logic [TW-1:0] m_typ;

    function automatic bit m_full();
        bit f = 1'b1;
        for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) begin
            m[i] = '{busy: 0, pj: 0, pk: 0, typ: '0, rob: '0, qj: '0, vj: '0,
                     qk: '0, vk: '0, imm: '0, seq: 0};
        end
        m_ndisp = 0;
        m_en = 0; m_rob = '0; m_j = '0; m_k = '0; m_imm = '0; m_typ = '0;
    endtask

    // One clock edge of the model, applying the rules to the current inputs.
    task automatic model_step();
        ent_t pre [RS_SIZE];
        bit   was_full;
        int   sel, best, age, f;
        if (!rst_n) begin model_reset(); return; end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 0;
            m_en = 0;
            return;
        end
        pre = m;
        was_full = m_full();
        sel = -1; best = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (pre[i].busy && !pre[i].pj && !pre[i].pk) begin
`ifdef ALU_RS_AGE_ORDER_EN
                age = m_ndisp - 1 - pre[i].seq;
                if (age > RS_SIZE) age = RS_SIZE;
                if (sel < 0 || age > best) begin sel = i; best = age; end
`else
                age = 0;
                if (sel < 0) sel = i;
`endif
            end
        end
        m_en = (sel >= 0);
        if (sel >= 0) begin
            m_rob = pre[sel].rob; m_j = pre[sel].vj; m_k = pre[sel].vk;
            m_imm = pre[sel].imm; m_typ = pre[sel].typ;
            m[sel].busy = 0;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (pre[i].busy && c_en) begin
                if (pre[i].pj && pre[i].qj == c_rob) begin m[i].pj = 0; m[i].vj = c_val; end
                if (pre[i].pk && pre[i].qk == c_rob) begin m[i].pk = 0; m[i].vk = c_val; end
            end
        end
        if (d_en && !was_full) begin
            f = -1;
            for (int i = RS_SIZE - 1; i >= 0; i--) if (!pre[i].busy) f = i;
            m[f].busy = 1; m[f].typ = d_type; m[f].rob = d_rob; m[f].imm = d_imm;
            m[f].qj = d_qj; m[f].qk = d_qk; m[f].vj = d_vj; m[f].vk = d_vk;
            m[f].pj = d_qjb; m[f].pk = d_qkb && !d_type[4];
            if (m[f].pj && c_en && d_qj == c_rob) begin m[f].pj = 0; m[f].vj = c_val; end
            if (m[f].pk && c_en && d_qk == c_rob) begin m[f].pk = 0; m[f].vk = c_val; end
            m[f].seq = m_ndisp;
            m_ndisp++;
        end
    endtask

    task automatic cmp_outputs();
        chk("alu_en", alu_en, m_en);
        chk("alu_rob_id", alu_rob_id, m_rob);
        chk("alu_data_j", alu_data_j, m_j);
        chk("alu_data_k", alu_data_k, m_k);
        chk("alu_imm", alu_imm, m_imm);
        chk("alu_type", alu_type, m_typ);
    endtask

    task automatic tick();
        chk("full", full, m_full());
        @(posedge clk);
        model_step();
        #1;
        cmp_outputs();
    endtask

    task automatic idle();
        rdy = 1; flush = 0; d_en = 0; c_en = 0;
        d_type = '0; d_rob = '0; d_qjb = 0; d_qj = '0; d_vj = '0;
        d_qkb = 0; d_qk = '0; d_vk = '0; d_imm = '0; c_rob = '0; c_val = '0;
    endtask

    task automatic set_disp(input logic [TW-1:0] t, input logic [31:0] rob,
                            input logic qjb, input logic [31:0] qj, input logic [31:0] vj,
                            input logic qkb, input logic [31:0] qk, input logic [31:0] vk,
                            input logic [31:0] imm);
        idle();
        d_en = 1; d_type = t; d_rob = rob; d_qjb = qjb; d_qj = qj; d_vj = vj;
        d_qkb = qkb; d_qk = qk; d_vk = vk; d_imm = imm;
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_full", full, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_rob", alu_rob_id, 0);
        chk("rst_alu_j", alu_data_j, 0);
        cmp_outputs();

        // Fully ready ADD issues one cycle after dispatch.
        set_disp(6'b000000, 3, 0, 0, 5, 0, 0, 7, 0); tick();
        chk("t1_dispatch_edge_en", alu_en, 0);
        idle(); tick();
        chk("t1_en", alu_en, 1); chk("t1_rob", alu_rob_id, 3);
        chk("t1_j", alu_data_j, 5); chk("t1_k", alu_data_k, 7);
        tick();
        chk("t1_drain_en", alu_en, 0);

        // Operand j woken by a later broadcast.
        set_disp(6'b000000, 20, 1, 9, 0, 0, 0, 1, 0); tick();
        idle(); tick();
        c_en = 1; c_rob = 9; c_val = 32'h10; tick();
        chk("t2_wake_edge_en", alu_en, 0);
        idle(); tick();
        chk("t2_en", alu_en, 1); chk("t2_j", alu_data_j, 32'h10); chk("t2_rob", alu_rob_id, 20);

        // Same-cycle CDB bypass at dispatch.
        set_disp(6'b010000, 21, 1, 4, 0, 1, 77, 0, 32'h1234);
        c_en = 1; c_rob = 4; c_val = 32'hAB; tick();
        idle(); tick();
        chk("t3_en", alu_en, 1); chk("t3_j", alu_data_j, 32'hAB);
        chk("t3_imm", alu_imm, 32'h1234); chk("t3_type", alu_type, 6'b010000);
        tick();

        // Fill every entry with pending operands; an extra dispatch is dropped.
        for (int i = 0; i < RS_SIZE; i++) begin
            set_disp(6'b000010, 100 + i, 1, 500 + i, 0, 1, 600 + i, 0, 0); tick();
        end
        idle();
        chk("t4_full", full, 1);
        set_disp(6'b000000, 55, 0, 0, 1, 0, 0, 2, 0); tick();
        idle(); tick();
        chk("t4_drop_en", alu_en, 0);
        chk("t4_still_full", full, 1);

        // Flush clears the station; later broadcasts wake nothing.
        flush = 1; tick();
        idle();
        chk("t5a_full", full, 0);
        for (int i = 0; i < 4; i++) begin
            set_disp(6'b000000, 200 + i, 1, 300 + i, 0, 0, 0, 0, 0); tick();
        end
        idle(); flush = 1; tick();
        idle();
        chk("t5_full", full, 0); chk("t5_en", alu_en, 0);
        c_en = 1; c_rob = 300; c_val = 1; tick();
        idle(); tick();
        chk("t5_no_issue", alu_en, 0);

        // Selection order: A sits in entry 1, B in entry 0, both woken together.
        set_disp(6'b000000, 40, 0, 0, 1, 0, 0, 1, 0); tick();
        set_disp(6'b000000, 41, 1, 60, 0, 0, 0, 2, 0); tick();
        chk("t6_x_issue", alu_rob_id, 40);
        set_disp(6'b000000, 42, 1, 60, 0, 0, 0, 3, 0); tick();
        idle(); c_en = 1; c_rob = 60; c_val = 32'h60; tick();
        idle(); tick();
`ifdef ALU_RS_AGE_ORDER_EN
        chk("t6_first", alu_rob_id, 41);
        tick();
        chk("t6_second", alu_rob_id, 42);
`else
        chk("t6_first", alu_rob_id, 42);
        tick();
        chk("t6_second", alu_rob_id, 41);
`endif
        chk("t6_second_j", alu_data_j, 32'h60);
        tick();

        // Hold: rdy_in low freezes outputs and state for three cycles.
        set_disp(6'b000000, 70, 0, 0, 7, 0, 0, 8, 0); tick();
        set_disp(6'b000000, 71, 0, 0, 9, 0, 0, 10, 0); tick();
        chk("hold_pre_rob", alu_rob_id, 70);
        for (int i = 0; i < 3; i++) begin
            set_disp(6'b000000, 99, 0, 0, 1, 0, 0, 1, 0);
            c_en = 1; c_rob = 99; c_val = 5; rdy = 0; flush = 1;
            tick();
            chk("hold_en", alu_en, 1); chk("hold_rob", alu_rob_id, 70);
        end
        idle(); tick();
        chk("hold_after_rob", alu_rob_id, 71); chk("hold_after_j", alu_data_j, 9);
        tick();
        chk("hold_drain_en", alu_en, 0);

        // Randomized traffic with small tag space to provoke matches.
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy    = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 49) == 0);
            d_en   = ($urandom_range(0, 9) < 6);
            d_type = TW'($urandom);
            d_rob  = $urandom_range(0, 15);
            d_qjb  = $urandom_range(0, 1);
            d_qj   = $urandom_range(0, 7);
            d_vj   = $urandom;
            d_qkb  = $urandom_range(0, 1);
            d_qk   = $urandom_range(0, 7);
            d_vk   = $urandom;
            d_imm  = $urandom;
            c_en   = $urandom_range(0, 1);
            c_rob  = $urandom_range(0, 7);
            c_val  = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
